// File: rtl/sort_pkg.sv
// Shared types and defaults for the streaming insertion sorter.
package sort_pkg;

  localparam int SORT_W  = 6;
  localparam int SORT_N  = 5;
  localparam int SORT_IW = $clog2(SORT_N);

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } sort_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_stream_if.sv
// Sample-in / sorted-out handshake bundle for sort_stream.
interface sort_stream_if
  import sort_pkg::*;
#(
  parameter int W = SORT_W
);

  logic         in_valid;
  logic [W-1:0] in_num;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_num;
  logic         out_median;
  logic         out_last;
  logic         out_ready;

  modport master (
    output in_valid,
    output in_num,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_num,
    input  out_median,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_num,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_num,
    output out_median,
    output out_last
  );

endinterface

// File: rtl/sort_insert_slot.sv
// One slot of the ascending insertion array: picks its next value from
// itself, its left neighbour or the incoming sample.
module sort_insert_slot
  import sort_pkg::*;
#(
  parameter int W = SORT_W
) (
  input  logic [W-1:0] own_val,
  input  logic [W-1:0] left_val,
  input  logic [W-1:0] new_val,
  input  logic         valid,
  input  logic         left_valid,
  output logic [W-1:0] next_val
);

  logic new_lt_left;
  logic new_lt_own;

  assign new_lt_left = new_val < left_val;
  assign new_lt_own  = new_val < own_val;

  // An empty slot acts as +inf, so it receives the sample or the shifted
  // neighbour; slots past the fill point (left not valid) never change.
  // Equal values do not compare less, which keeps ties in arrival order.
  always_comb begin
    next_val = own_val;
    if (left_valid && new_lt_left) begin
      next_val = left_val;
    end else if (left_valid && (!valid || new_lt_own)) begin
      next_val = new_val;
    end
  end

endmodule

// File: rtl/sort_stream.sv
// Serial sorter: loads N samples into an ascending array, then streams
// them out smallest first with median and last-of-frame flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   LOAD  | in_ready high; each accepted sample is inserted in order
//   DRAIN | out_valid high; arr[rd_idx] presented until out_ready
module sort_stream
  import sort_pkg::*;
#(
  parameter int W = SORT_W,
  parameter int N = SORT_N
) (
  input logic         clk,
  input logic         rst,
  sort_stream_if.slave bus
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] MED_IDX  = IW'(N / 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  sort_state_t   state;
  logic [IW-1:0] wr_cnt;
  logic [IW-1:0] rd_idx;
  logic [W-1:0]  arr     [N];
  logic [W-1:0]  arr_nxt [N];

  for (genvar i = 0; i < N; i++) begin : g_slot
    logic [W-1:0] left_val;
    logic         left_valid;
    logic         slot_valid;

    // Slot 0 sees an implicit -inf neighbour: zero never exceeds a sample.
    if (i == 0) begin : g_head
      assign left_val   = '0;
      assign left_valid = 1'b1;
    end else begin : g_body
      assign left_val   = arr[i-1];
      assign left_valid = IW'(i - 1) < wr_cnt;
    end

    assign slot_valid = IW'(i) < wr_cnt;

    sort_insert_slot #(
      .W (W)
    ) u_slot (
      .own_val    (arr[i]),
      .left_val   (left_val),
      .new_val    (bus.in_num),
      .valid      (slot_valid),
      .left_valid (left_valid),
      .next_val   (arr_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      wr_cnt <= '0;
      rd_idx <= '0;
      for (int i = 0; i < N; i++) begin
        arr[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            arr <= arr_nxt;
            if (wr_cnt == LAST_IDX) begin
              wr_cnt <= '0;
              state  <= DRAIN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              state  <= LOAD;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Ready is masked by rst so a source never sees a handshake being reset away.
  assign bus.in_ready   = (state == LOAD) && !rst;
  assign bus.out_valid  = (state == DRAIN);
  assign bus.out_num    = arr[rd_idx];
  assign bus.out_median = (state == DRAIN) && (rd_idx == MED_IDX);
  assign bus.out_last   = (state == DRAIN) && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_sort_stream.sv
// Bench for sort_stream: directed frames plus random frames with input
// gaps and output stalls, checked against a sorted-list reference.
module tb_sort_stream;
  import sort_pkg::*;

  localparam int W = SORT_W;
  localparam int N = SORT_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_stream_if #(.W(W)) bus ();

  sort_stream #(
    .W (W),
    .N (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the frame's values in ascending order.
  function automatic void sort_ref(input int v[N], output int s[N]);
    int t;
    s = v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1 chk("rst_in_ready_hi", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_num", int'(bus.out_num), 0);
    chk("rst_out_median", int'(bus.out_median), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_out_valid", int'(bus.out_valid), 0);
  endtask

  task automatic feed(input int v[N], input int n_in, input bit gaps);
    for (int k = 0; k < n_in; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_num   = W'($urandom_range(0, 63));
          chk("gap_in_ready", int'(bus.in_ready), 1);
          chk("gap_out_valid", int'(bus.out_valid), 0);
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_num   = W'(v[k]);
      chk("load_in_ready", int'(bus.in_ready), 1);
      chk("load_out_valid", int'(bus.out_valid), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int e[N], input int n_out, input int stall_at,
                       input int stall_len, input bit hold_iv);
    for (int k = 0; k < n_out; k++) begin
      if (hold_iv) begin
        bus.in_valid = 1'b1;
        bus.in_num   = W'($urandom_range(0, 63));
      end
      if (k == stall_at) begin
        repeat (stall_len) begin
          bus.out_ready = 1'b0;
          chk("stall_out_valid", int'(bus.out_valid), 1);
          chk("stall_out_num", int'(bus.out_num), e[k]);
          chk("stall_median", int'(bus.out_median), int'(k == N / 2));
          chk("stall_last", int'(bus.out_last), int'(k == N - 1));
          @(negedge clk);
        end
      end
      bus.out_ready = 1'b1;
      chk("drain_out_valid", int'(bus.out_valid), 1);
      chk("drain_in_ready", int'(bus.in_ready), 0);
      chk("drain_out_num", int'(bus.out_num), e[k]);
      chk("drain_median", int'(bus.out_median), int'(k == N / 2));
      chk("drain_last", int'(bus.out_last), int'(k == N - 1));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (n_out == N) begin
      chk("after_frame_out_valid", int'(bus.out_valid), 0);
      chk("after_frame_in_ready", int'(bus.in_ready), 1);
    end
  endtask

  task automatic run_frame(input int v[N], input bit gaps, input int stall_at,
                           input int stall_len, input bit hold_iv);
    int s[N];
    sort_ref(v, s);
    feed(v, N, gaps);
    drain(s, N, stall_at, stall_len, hold_iv);
  endtask

  initial begin
    int f[N];
    int s[N];

    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    @(negedge clk);

    f = '{12, 3, 40, 7, 25};
    run_frame(f, 1'b0, -1, 0, 1'b0);

    f = '{63, 0, 63, 0, 31};
    run_frame(f, 1'b0, -1, 0, 1'b0);

    f = '{5, 4, 3, 2, 1};
    run_frame(f, 1'b1, 2, 3, 1'b0);

    // Input held high while draining; next frame follows with no idle cycle.
    f = '{20, 50, 10, 40, 30};
    run_frame(f, 1'b0, 1, 2, 1'b1);
    f = '{1, 1, 2, 2, 1};
    run_frame(f, 1'b0, -1, 0, 1'b0);

    // Reset after three accepts discards the partial frame.
    f = '{60, 61, 62, 0, 0};
    feed(f, 3, 1'b0);
    do_reset();
    f = '{9, 8, 7, 6, 5};
    run_frame(f, 1'b0, -1, 0, 1'b0);

    // Reset part-way through the drain.
    f = '{33, 11, 22, 55, 44};
    sort_ref(f, s);
    feed(f, N, 1'b0);
    drain(s, 2, -1, 0, 1'b0);
    do_reset();
    f = '{17, 16, 18, 15, 19};
    run_frame(f, 1'b1, -1, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++)
        f[k] = (r % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      run_frame(f, bit'($urandom_range(0, 1)), int'($urandom_range(0, N)),
                int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
